// File: rtl/mult_div_pkg.sv
// Shared constants and FSM encoding for the multicycle signed multiply/divide unit.
package mult_div_pkg;

  localparam int ITER  = 32;
  localparam int CNT_W = $clog2(ITER);
  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MULT   = 3'd1,
    ST_DIV    = 3'd2,
    ST_FINISH = 3'd3,
    ST_DZERO  = 3'd4
  } state_t;

endpackage

// File: rtl/mult_div_div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift {rem, quo} left,
// trial-subtract the divisor, keep the difference when it does not go negative.
module mult_div_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = {1'b0, shifted} - {2'b00, dvs};

  always_comb begin
    rem_nxt = shifted[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH+1]) begin
      rem_nxt = trial[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mult_div.sv
// Multicycle signed MULT (radix-2 Booth) / DIV (restoring on magnitudes) with HI/LO result registers.
// Handshake: a start pulse is taken only in IDLE; busy is high until the state returns to IDLE.
module mult_div
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output state_t           dbg_state
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opb;
  logic             q_m1, is_div, neg_q, neg_r;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH-1:0] abs_a, abs_b, rem_nxt, quo_nxt;
  logic             last_iter;

  // Magnitudes are unsigned, so |MIN_INT| is carried exactly as 0x80000000.
  assign abs_a     = a_in[WIDTH-1] ? -a_in : a_in;
  assign abs_b     = b_in[WIDTH-1] ? -b_in : b_in;
  assign last_iter = (cnt == CNT_W'(ITER - 1));
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start_mult)     state_nxt = ST_MULT;
        else if (start_div) state_nxt = (b_in == '0) ? ST_DZERO : ST_DIV;
      end
      ST_MULT, ST_DIV: if (last_iter) state_nxt = ST_FINISH;
      ST_FINISH, ST_DZERO: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Sign-extended by one bit so subtracting MIN_INT cannot wrap before the shift.
  always_comb begin
    booth_sum = {acc_hi[WIDTH-1], acc_hi};
    case ({acc_lo[0], q_m1})
      2'b01:   booth_sum = {acc_hi[WIDTH-1], acc_hi} + {opb[WIDTH-1], opb};
      2'b10:   booth_sum = {acc_hi[WIDTH-1], acc_hi} - {opb[WIDTH-1], opb};
      default: booth_sum = {acc_hi[WIDTH-1], acc_hi};
    endcase
  end

  mult_div_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem     (acc_hi),
    .quo     (acc_lo),
    .dvs     (opb),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opb      <= '0;
      q_m1     <= 1'b0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (start_mult) begin
            acc_hi <= '0;
            acc_lo <= b_in;
            opb    <= a_in;
            q_m1   <= 1'b0;
            is_div <= 1'b0;
          end else if (start_div && (b_in != '0)) begin
            acc_hi <= '0;
            acc_lo <= abs_a;
            opb    <= abs_b;
            is_div <= 1'b1;
            neg_q  <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
            neg_r  <= a_in[WIDTH-1];
          end
        end
        ST_MULT: begin
          acc_hi <= booth_sum[WIDTH:1];
          acc_lo <= {booth_sum[0], acc_lo[WIDTH-1:1]};
          q_m1   <= acc_lo[0];
          cnt    <= cnt + CNT_W'(1);
        end
        ST_DIV: begin
          acc_hi <= rem_nxt;
          acc_lo <= quo_nxt;
          cnt    <= cnt + CNT_W'(1);
        end
        ST_FINISH: begin
          done <= 1'b1;
          if (is_div) begin
            hi_out <= neg_r ? -acc_hi : acc_hi;
            lo_out <= neg_q ? -acc_lo : acc_lo;
          end else begin
            hi_out <= acc_hi;
            lo_out <= acc_lo;
          end
        end
        ST_DZERO: div_zero <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div.sv
// Directed bench for mult_div: hand-computed products/quotients, latency, divide-by-zero and async reset.
module tb_mult_div;
  import mult_div_pkg::*;

  logic        clk;
  logic        reset;
  logic        start_mult;
  logic        start_div;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  state_t      dbg_state;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  mult_div #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .a_in       (a_in),
    .b_in       (b_in),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .hi_out     (hi_out),
    .lo_out     (lo_out),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // op: 0 multiply, 1 divide, 2 both starts together (multiply must win)
  task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string tag);
    int cycles;
    int busy_drops;
    int dz_seen;
    logic [63:0] exp;
    exp_q.push_back({exp_hi, exp_lo});
    @(negedge clk);
    a_in = a;
    b_in = b;
    start_mult = (op != 1);
    start_div  = (op != 0);
    @(negedge clk);
    start_mult = 1'b0;
    start_div  = 1'b0;
    cycles = 0;
    busy_drops = 0;
    dz_seen = 0;
    while (!done && cycles < 100) begin
      if (!busy) busy_drops++;
      if (div_zero) dz_seen++;
      @(negedge clk);
      cycles++;
    end
    exp = exp_q.pop_front();
    check({tag, "_latency"}, 64'(cycles), 64'd33);
    check({tag, "_busy_held"}, 64'(busy_drops), 64'd0);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_div_zero"}, 64'(dz_seen), 64'd0);
    check({tag, "_result"}, {hi_out, lo_out}, exp);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int done_seen;
    reset      = 1'b0;
    start_mult = 1'b0;
    start_div  = 1'b0;
    a_in       = '0;
    b_in       = '0;
    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_div_zero", 64'(div_zero), 64'd0);
    check("rst_hilo", {hi_out, lo_out}, 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    repeat (2) @(negedge clk);
    reset = 1'b1;

    run_op(0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mul_7_m3");
    run_op(0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mul_min_min");
    run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, "mul_m1_m1");
    run_op(0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, "mul_shift");
    run_op(1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
    run_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_min_m1");
    run_op(1, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, "div_100_7");
    run_op(1, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7_m2");
    run_op(1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, "div_m7_m2");
    run_op(1, 32'h8000_0000, 32'd3,         32'hFFFF_FFFE, 32'hD555_5556, "div_min_3");
    run_op(2, 32'd6,         32'd0,         32'h0000_0000, 32'h0000_0000, "both_starts");

    // divide by zero must leave the preloaded HI/LO untouched
    run_op(0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "preload");
    @(negedge clk);
    a_in = 32'd5;
    b_in = 32'd0;
    start_div = 1'b1;
    @(negedge clk);
    start_div = 1'b0;
    check("dz_busy_e0", 64'(busy), 64'd1);
    check("dz_flag_e0", 64'(div_zero), 64'd0);
    @(negedge clk);
    check("dz_flag_e1", 64'(div_zero), 64'd1);
    check("dz_busy_e1", 64'(busy), 64'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    check("dz_flag_e2plus", 64'(div_zero), 64'd0);
    check("dz_done_seen", 64'(done_seen), 64'd0);
    check("dz_hilo_kept", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFEB);

    // mid-operation reset after an ignored start_div
    @(negedge clk);
    a_in = 32'd3;
    b_in = 32'd4;
    start_mult = 1'b1;
    @(negedge clk);
    start_mult = 1'b0;
    repeat (9) @(negedge clk);
    start_div = 1'b1;
    @(negedge clk);
    start_div = 1'b0;
    repeat (9) @(negedge clk);
    check("ign_state_mult", 64'(dbg_state), 64'(ST_MULT));
    check("ign_busy", 64'(busy), 64'd1);
    #3;
    reset = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_div_zero", 64'(div_zero), 64'd0);
    check("arst_hilo", {hi_out, lo_out}, 64'd0);
    check("arst_state", 64'(dbg_state), 64'(ST_IDLE));
    @(negedge clk);
    reset = 1'b1;
    run_op(0, 32'd3, 32'd4, 32'h0000_0000, 32'h0000_000C, "mul_3_4_post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div.md
Name: mult_div

Overview:
- Multicycle signed multiply/divide unit for the processor datapath; executes MULT and DIV on operands from the A and B registers.
- Holds the 64-bit result in HI/LO registers.
- hi_out and lo_out feed the write-back data selector's RegHIOut and RegLOOut inputs (MemToReg select 4 and 5).
- The control unit starts an operation with a one-cycle pulse, stalls on busy, and samples div_zero for the exception path.

Parameters:
- WIDTH, 32, operand width; hi_out and lo_out are each WIDTH bits.
- ITER, 32, iteration count per operation; must equal WIDTH.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start_mult  in  1  one-cycle pulse: begin signed multiply of a_in by b_in
- start_div  in  1  one-cycle pulse: begin signed divide, a_in divided by b_in
- a_in  in  WIDTH  operand A (multiplicand or dividend); sampled only on the start edge
- b_in  in  WIDTH  operand B (multiplier or divisor); sampled only on the start edge
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when hi_out and lo_out have just been updated
- div_zero  out  1  one-cycle pulse when a divide is started with b_in == 0
- hi_out  out  WIDTH  HI register: product[63:32], or remainder
- lo_out  out  WIDTH  LO register: product[31:0], or quotient

Behaviour:
- Reset (reset = 0, asynchronous): state IDLE; busy = 0, done = 0, div_zero = 0, hi_out = 0, lo_out = 0; counter and working registers cleared. Asserting reset mid-operation aborts it; nothing is written.
- States: IDLE, MULT, DIV, FINISH, DZERO.
- IDLE:
  - start_mult = 1 -> MULT, with a_in/b_in latched.
  - Else start_div = 1 with b_in != 0 -> DIV, with a_in/b_in latched.
  - Else start_div = 1 with b_in == 0 -> DZERO.
  - If start_mult and start_div are high together, multiply has priority; the divide request is dropped.
- Start pulses are ignored unless the state is IDLE. They are not queued.
- MULT, radix-2 Booth:
  - Accumulator {P_hi, P_lo, q_-1} is 65 bits.
  - Each cycle: add, subtract or do nothing to P_hi according to {P_lo[0], q_-1}, then arithmetic shift right by 1.
  - Runs ITER cycles, then -> FINISH.
- DIV, restoring, on magnitudes:
  - |a| and |b| are computed at the start edge; |MIN_INT| is held as an unsigned 0x80000000.
  - Each cycle: shift {rem, quo} left by 1 and trial-subtract |b|; keep the result if non-negative and set the quotient bit.
  - Runs ITER cycles, then -> FINISH.
- FINISH:
  - Multiply: hi_out/lo_out <= product.
  - Divide: the quotient is negated if the operand signs differ (truncates toward zero); the remainder takes the dividend's sign.
  - done = 1 for this one cycle, then -> IDLE.
  - MIN_INT / -1 gives lo = 0x80000000, hi = 0, with no exception.
- DZERO: div_zero = 1 for one cycle; hi_out/lo_out unchanged; done stays 0; -> IDLE.
- busy = 1 in MULT, DIV, FINISH and DZERO.
- Latency: start sampled at edge 0; iterations at edges 1..32; registers written and done asserted at edge 33. A new start is accepted at edge 34 at the earliest.
- hi_out/lo_out change only in FINISH. They hold their value indefinitely otherwise, including across a DZERO.
- All arithmetic is modulo 2^WIDTH per half; no overflow flag.

Decomposition:
- Shared package: state encoding constants (IDLE..DZERO), ITER, and the MIN_INT constant.
- One sub-module, div_step: combinational single restoring-division iteration (rem, quo, divisor in; next rem, next quo out).
- The Booth step stays inline; it is small.

Test Plan:
- 7 x -3 -> done at edge 33; hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; busy high for edges 1..33.
- 0x80000000 x 0x80000000 -> hi = 0x40000000, lo = 0x00000000.
- -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0; div_zero stays 0.
- Preload hi/lo with 7 x -3, then divide 5 / 0 -> div_zero pulses at edge 1; done never asserts; hi/lo keep 0xFFFFFFFF / 0xFFFFFFEB.
- Multiply 3 x 4: pulse start_div at edge 10, then drive reset low at edge 20 -> the start_div is ignored; all outputs go to 0 immediately (asynchronously); after reset release, a 3 x 4 gives lo = 12, hi = 0.
